sample_clock_gen: RTL and testbench

Parametrised sample-rate generator for the audio subsystem. It replaces the fixed power-of-two sample divider with a phase accumulator, so any sample rate is a rational fraction of clk. It also adds a per-sample strobe and a TDM channel sequencer that steps the synth voices through one channel per cycle after each sample tick. Runtime rate changes are glitch-free and take effect only at a sample boundary.

---
 rtl/sample_clock_gen_if.sv | 41 ++++
 rtl/sample_clock_gen.sv | 146 ++++++++++++++
 tb/tb_sample_clock_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sample_clock_gen_if.sv
// Control and status bundle for sample_clock_gen: rate programming in, sample/channel strobes out.
// sample_ts exists only when SAMPLE_CLOCK_TSTAMP_EN is defined.
interface sample_clock_gen_if #(
    parameter int ACC_W  = 16,
    parameter int NUM_CH = 4,
    parameter int TS_W   = 32
);
    localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                en;
    logic [ACC_W-1:0]    inc_in;
    logic                inc_load;
    logic                sample_clock;
    logic                sample_stb;
    logic [NUM_CH-1:0]   ch_stb;
    logic [CH_IDX_W-1:0] ch_idx;
    logic                overrun;
`ifdef SAMPLE_CLOCK_TSTAMP_EN
    logic [TS_W-1:0]     sample_ts;

    modport master (
        output en, inc_in, inc_load,
        input  sample_clock, sample_stb, ch_stb, ch_idx, overrun, sample_ts
    );

    modport slave (
        input  en, inc_in, inc_load,
        output sample_clock, sample_stb, ch_stb, ch_idx, overrun, sample_ts
    );
`else
    modport master (
        output en, inc_in, inc_load,
        input  sample_clock, sample_stb, ch_stb, ch_idx, overrun
    );

    modport slave (
        input  en, inc_in, inc_load,
        output sample_clock, sample_stb, ch_stb, ch_idx, overrun
    );
`endif
endinterface

// File: rtl/sample_clock_gen.sv
// Phase-accumulator sample-rate generator with per-sample strobe and TDM channel sequencer.
// Optional sample timestamp counter enabled by defining SAMPLE_CLOCK_TSTAMP_EN.
module sample_clock_gen #(
    parameter int          ACC_W       = 16,
    parameter int          NUM_CH      = 4,
    parameter int unsigned INC_DEFAULT = 256,
    parameter int          TS_W        = 32
) (
    input logic              clk,
    input logic              rst_n,
    sample_clock_gen_if.slave bus
);
    localparam int                  CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NUM_CH - 1);
    localparam logic [ACC_W-1:0]    INC_RST  = ACC_W'(INC_DEFAULT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEQ  = 1'b1;

    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("sample_clock_gen: NUM_CH must be at least 1");
    end
    if (TS_W < 1) begin : g_bad_ts_w
        $error("sample_clock_gen: TS_W must be at least 1");
    end

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_IDX_W-1:0] idx);
        onehot = NUM_CH'(1) << idx;
    endfunction

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    active_inc_q, active_inc_d;
    logic [ACC_W-1:0]    pending_inc_q, pending_inc_d;
    logic                pend_q, pend_d;
    logic                sclk_q, sclk_d;
    logic                stb_q, stb_d;
    logic [0:0]          state_q, state_d;
    logic [CH_IDX_W-1:0] idx_q, idx_d;
    logic                ovr_q, ovr_d;

    logic [ACC_W:0]      sum;
    logic                carry;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, active_inc_q};
        carry = bus.en & sum[ACC_W];

        acc_d  = bus.en ? sum[ACC_W-1:0] : acc_q;
        sclk_d = bus.en ? acc_q[ACC_W-1] : sclk_q;
        stb_d  = carry;

        active_inc_d  = active_inc_q;
        pending_inc_d = pending_inc_q;
        pend_d        = pend_q;
        if (!bus.en) begin
            // Stopped accumulator: no boundary to wait for, so apply immediately.
            if (bus.inc_load) begin
                active_inc_d  = bus.inc_in;
                pending_inc_d = bus.inc_in;
                pend_d        = 1'b0;
            end
        end else begin
            // A coincident load is deferred to the following boundary.
            if (carry && pend_q) begin
                active_inc_d = pending_inc_q;
            end
            if (bus.inc_load) begin
                pending_inc_d = bus.inc_in;
                pend_d        = 1'b1;
            end else if (carry) begin
                pend_d = 1'b0;
            end
        end

        state_d = state_q;
        idx_d   = idx_q;
        ovr_d   = ovr_q;
        if (carry) begin
            if ((state_q == ST_SEQ) && (idx_q != LAST_CH)) begin
                ovr_d = 1'b1;
            end
            state_d = ST_SEQ;
            idx_d   = '0;
        end else if (state_q == ST_SEQ) begin
            if (idx_q == LAST_CH) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + CH_IDX_W'(1);
            end
        end
        if (!bus.en) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q         <= '0;
            active_inc_q  <= INC_RST;
            pending_inc_q <= INC_RST;
            pend_q        <= 1'b0;
            sclk_q        <= 1'b0;
            stb_q         <= 1'b0;
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            ovr_q         <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            active_inc_q  <= active_inc_d;
            pending_inc_q <= pending_inc_d;
            pend_q        <= pend_d;
            sclk_q        <= sclk_d;
            stb_q         <= stb_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            ovr_q         <= ovr_d;
        end
    end

    assign bus.sample_clock = sclk_q;
    assign bus.sample_stb   = stb_q;
    assign bus.ch_stb       = (state_q == ST_SEQ) ? onehot(idx_q) : '0;
    assign bus.ch_idx       = idx_q;
    assign bus.overrun      = ovr_q;

`ifdef SAMPLE_CLOCK_TSTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    // Advances on the same edge that raises sample_stb.
    always_comb begin
        ts_d = carry ? ts_q + TS_W'(1) : ts_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign bus.sample_ts = ts_q;
`endif

endmodule

// File: tb/tb_sample_clock_gen.sv
// Randomised scoreboard bench for sample_clock_gen against a cycle-level arithmetic reference model.
module tb_sample_clock_gen;
    localparam int          ACC_W       = 16;
    localparam int          NUM_CH      = 4;
    localparam int unsigned INC_DEFAULT = 256;
    localparam int          TS_W        = 32;
    localparam int          CIW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam longint      MOD         = longint'(1) << ACC_W;
    localparam longint      TS_MASK     = (longint'(1) << TS_W) - 1;

    typedef struct {
        logic              sclk;
        logic              stb;
        logic [NUM_CH-1:0] chs;
        logic [CIW-1:0]    idx;
        logic              ovr;
        logic [TS_W-1:0]   ts;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sample_clock_gen_if #(.ACC_W(ACC_W), .NUM_CH(NUM_CH), .TS_W(TS_W)) bus();

    sample_clock_gen #(
        .ACC_W(ACC_W), .NUM_CH(NUM_CH), .INC_DEFAULT(INC_DEFAULT), .TS_W(TS_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Reference model: phase as an integer, sequencer as "cycles since last tick".
    longint m_acc, m_act, m_pendv, m_ts;
    bit     m_pend, m_ovr, m_sclk, m_stb;
    int     m_age;

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0; m_act = INC_DEFAULT; m_pendv = INC_DEFAULT; m_pend = 0;
        m_age = NUM_CH; m_ovr = 0; m_sclk = 0; m_stb = 0; m_ts = 0;
    endfunction

    function automatic void model_step(input bit en, input longint inc, input bit load);
        bit tick;
        tick = en && (m_acc + m_act >= MOD);
        if (en) begin
            m_sclk = (m_acc >= MOD / 2);
            m_acc  = (m_acc + m_act) % MOD;
        end
        if (!en) begin
            if (load) begin m_act = inc; m_pendv = inc; m_pend = 0; end
        end else begin
            if (tick && m_pend) m_act = m_pendv;
            if (tick) m_pend = 0;
            if (load) begin m_pendv = inc; m_pend = 1; end
        end
        if (tick) begin
            if (m_age < NUM_CH - 1) m_ovr = 1;
            m_age = 0;
            m_ts  = (m_ts + 1) & TS_MASK;
        end else if (m_age < NUM_CH) begin
            m_age++;
        end
        if (!en) m_ovr = 0;
        m_stb = tick;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.sclk = m_sclk;
        e.stb  = m_stb;
        e.chs  = '0;
        e.idx  = '0;
        if (m_age < NUM_CH) begin
            e.chs = NUM_CH'(1) << m_age;
            e.idx = CIW'(m_age);
        end
        e.ovr = m_ovr;
        e.ts  = TS_W'(m_ts);
        return e;
    endfunction

    // Drive one cycle of stimulus at negedge+1; expected post-edge state goes to the scoreboard.
    task automatic step(input bit en, input longint inc, input bit load);
        bus.en       = en;
        bus.inc_in   = ACC_W'(inc);
        bus.inc_load = load;
        model_step(en, inc, load);
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample_clock"}, bus.sample_clock, 0);
        chk({tag, "_sample_stb"}, bus.sample_stb, 0);
        chk({tag, "_ch_stb"}, bus.ch_stb, 0);
        chk({tag, "_ch_idx"}, bus.ch_idx, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
`ifdef SAMPLE_CLOCK_TSTAMP_EN
        chk({tag, "_sample_ts"}, bus.sample_ts, 0);
`endif
    endtask

    // Monitor: every cycle the DUT presents a state, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sample_clock", bus.sample_clock, e.sclk);
                chk("sample_stb", bus.sample_stb, e.stb);
                chk("ch_stb", bus.ch_stb, e.chs);
                chk("ch_idx", bus.ch_idx, e.idx);
                chk("overrun", bus.overrun, e.ovr);
`ifdef SAMPLE_CLOCK_TSTAMP_EN
                chk("sample_ts", bus.sample_ts, e.ts);
`endif
            end
        end
    end

    initial begin
        bit     found;
        bit     en_r, ld_r;
        longint inc_r;

        rst_n = 1'b1;
        bus.en = 1'b0; bus.inc_in = '0; bus.inc_load = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero("rst");
        repeat (3) @(negedge clk);
        #1 chk_zero("rst_held");
        rst_n = 1'b1;
        model_reset();

        // Default legacy rate.
        run(600);

        // Fractional rate 0x3000 loaded while stopped.
        step(1'b0, 'h3000, 1'b1);
        run(200);

        // Deferred rate change at mid-period, second load overriding the first.
        step(1'b0, 'h0100, 1'b1);
        run(128);
        step(1'b1, 'h0200, 1'b1);
        run(40);
        step(1'b1, 'h0180, 1'b1);
        run(600);

        // Overrunning rate, then a one-cycle en drop clears overrun.
        step(1'b0, 'h8000, 1'b1);
        run(20);
        step(1'b0, 0, 1'b0);
        run(20);

        // Randomised operation.
        for (int i = 0; i < 3000; i++) begin
            en_r = ($urandom_range(0, 15) != 0);
            ld_r = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0: inc_r = $urandom_range(0, 'h4000);
                1: inc_r = $urandom_range(0, 'hFFFF);
                2: inc_r = 0;
                default: inc_r = $urandom_range(1, 'h400);
            endcase
            step(en_r, inc_r, ld_r);
        end

        // Asynchronous reset in the middle of a channel sequence.
        step(1'b0, 'h0100, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            step(1'b1, 0, 1'b0);
            if (m_age == 2) found = 1'b1;
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL midseq_wait: ch_idx=2 not reached within 1000 cycles");
        end
        chk("midrst_pre_ch_idx", bus.ch_idx, 2);
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        run(300);

`ifdef SAMPLE_CLOCK_TSTAMP_EN
        step(1'b0, 'h4000, 1'b1);
        run(80);
`endif

        bus.en = 1'b0; bus.inc_load = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
